// File: rtl/cipher_pkg.sv
// Shared constants, types and helpers for the 5-round 64-bit word cipher
// (encryption and decryption sides).
package cipher_pkg;

  localparam int unsigned WORD_W     = 16;
  localparam int unsigned NUM_ROUNDS = 5;
  localparam int unsigned ROT_AMT    = 1;
  localparam int unsigned DATA_WIDTH = 64;
  localparam int unsigned CTRL_WIDTH = 8;
  localparam int unsigned KEY_WIDTH  = 80;

  // Subkey indices: K0 is the most significant 16 bits of the key.
  localparam int unsigned K0_IDX = 0;
  localparam int unsigned K1_IDX = 1;
  localparam int unsigned K2_IDX = 2;
  localparam int unsigned K3_IDX = 3;
  localparam int unsigned K4_IDX = 4;

  typedef logic [WORD_W-1:0] word_t;

  // One 64-bit data word split into its four 16-bit lanes, w0 = [63:48].
  typedef struct packed {
    word_t w0;
    word_t w1;
    word_t w2;
    word_t w3;
  } block_t;

  function automatic word_t rotl16(input word_t x);
    return word_t'((x << ROT_AMT) | (x >> (WORD_W - ROT_AMT)));
  endfunction

  function automatic word_t rotr16(input word_t x);
    return word_t'((x >> ROT_AMT) | (x << (WORD_W - ROT_AMT)));
  endfunction

  function automatic word_t subkey(input logic [KEY_WIDTH-1:0] key, input int unsigned idx);
    return key[KEY_WIDTH - 1 - WORD_W * idx -: WORD_W];
  endfunction

endpackage

// File: rtl/top_decryption_if.sv
// Packet stream bundle around the decryption pipeline.
//   in_data/in_ctrl/in_wr/in_rdy    : upstream ciphertext/header stream
//   out_data/out_ctrl/out_wr/out_rdy : downstream plaintext/header stream
// slave  : the decryption block's view
// master : the source/sink environment's view
interface top_decryption_if;
  import cipher_pkg::*;

  logic [DATA_WIDTH-1:0] in_data;
  logic [CTRL_WIDTH-1:0] in_ctrl;
  logic                  in_wr;
  logic                  in_rdy;
  logic [DATA_WIDTH-1:0] out_data;
  logic [CTRL_WIDTH-1:0] out_ctrl;
  logic                  out_wr;
  logic                  out_rdy;

  modport slave (
    input  in_data, in_ctrl, in_wr, out_rdy,
    output in_rdy, out_data, out_ctrl, out_wr
  );

  modport master (
    output in_data, in_ctrl, in_wr, out_rdy,
    input  in_rdy, out_data, out_ctrl, out_wr
  );
endinterface

// File: rtl/single_stage_decryption.sv
// One decryption round as a pipeline stage.
//   clk, rst_n : clock, async active-low reset
//   blk_i      : four 16-bit input words
//   ctrl_i     : ctrl travelling with the word (nonzero = header, pass through)
//   subkey_i   : 16-bit round subkey
//   valid_i    : word valid
//   enable_i   : advance the stage (deasserted while the pipeline stalls)
//   blk_o, ctrl_o, valid_o : registered stage contents
module single_stage_decryption
  import cipher_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  block_t                blk_i,
  input  logic [CTRL_WIDTH-1:0] ctrl_i,
  input  word_t                 subkey_i,
  input  logic                  valid_i,
  input  logic                  enable_i,
  output block_t                blk_o,
  output logic [CTRL_WIDTH-1:0] ctrl_o,
  output logic                  valid_o
);

  block_t                blk_d;
  block_t                blk_q;
  logic [CTRL_WIDTH-1:0] ctrl_q;
  logic                  valid_q;

  // Inverse round: {y0,y1,y2,y3} -> {rotr(y3^K), y0, y1, y2}; headers untouched.
  always_comb begin
    blk_d = blk_i;
    if (ctrl_i == '0) begin
      blk_d.w0 = rotr16(blk_i.w3 ^ subkey_i);
      blk_d.w1 = blk_i.w0;
      blk_d.w2 = blk_i.w1;
      blk_d.w3 = blk_i.w2;
    end
  end

  // Stage registers; hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_q   <= '0;
      ctrl_q  <= '0;
      valid_q <= 1'b0;
    end else if (enable_i) begin
      blk_q   <= blk_d;
      ctrl_q  <= ctrl_i;
      valid_q <= valid_i;
    end
  end

  assign blk_o   = blk_q;
  assign ctrl_o  = ctrl_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/top_decryption.sv
// Five-stage decryption pipeline for the 64-bit data / 8-bit ctrl stream.
// Payload words (ctrl == 0) are decrypted with subkeys K4..K0; header words
// pass through with identical latency. Full out_rdy backpressure.
//   clk, rst_n : clock, async active-low reset
//   key        : 80-bit cipher key, only changed while the pipeline is empty
//   bus        : in_*/out_* stream handshake (slave side)
module top_decryption
  import cipher_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [KEY_WIDTH-1:0] key,
  top_decryption_if.slave      bus
);

  // Index 0 is the input word, index s+1 the output of stage s.
  block_t                stg_blk   [NUM_ROUNDS+1];
  logic [CTRL_WIDTH-1:0] stg_ctrl  [NUM_ROUNDS+1];
  logic                  stg_valid [NUM_ROUNDS+1];
  logic                  stall_c;

  // Whole pipeline freezes while the last stage holds an unaccepted word.
  assign stall_c    = stg_valid[NUM_ROUNDS] && !bus.out_rdy;
  assign bus.in_rdy = !stall_c;

  assign stg_blk[0]   = block_t'(bus.in_data);
  assign stg_ctrl[0]  = bus.in_ctrl;
  assign stg_valid[0] = bus.in_wr;

  for (genvar s = 0; s < NUM_ROUNDS; s++) begin : g_stage
    // Subkeys applied in reverse: first stage uses K4, last uses K0.
    localparam int unsigned KIDX = NUM_ROUNDS - 1 - s;

    single_stage_decryption u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .blk_i    (stg_blk[s]),
      .ctrl_i   (stg_ctrl[s]),
      .subkey_i (subkey(key, KIDX)),
      .valid_i  (stg_valid[s]),
      .enable_i (!stall_c),
      .blk_o    (stg_blk[s+1]),
      .ctrl_o   (stg_ctrl[s+1]),
      .valid_o  (stg_valid[s+1])
    );
  end

  assign bus.out_wr   = stg_valid[NUM_ROUNDS];
  assign bus.out_data = DATA_WIDTH'(stg_blk[NUM_ROUNDS]);
  assign bus.out_ctrl = stg_ctrl[NUM_ROUNDS];

endmodule
